// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash controllers.
// Frame layout: 8-bit command, 24-bit address, 16 data bits.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 48;
  localparam int         DATA_BITS  = 16;
  localparam int         BIT_CNT_W  = 6;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: CLKDIV clk cycles per half-period, idle low while disabled.
// rise/fall strobe in the cycle whose closing edge moves sck high/low.
module spi_sck_gen #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int               DIV_W    = $clog2(CLKDIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic             wrap;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    wrap    = en && (div_q == DIV_LAST);
    rise    = wrap && !phase_q;
    fall    = wrap && phase_q;
    if (!en) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      div_d   = '0;
      phase_d = !phase_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign sck = phase_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI flash controller: issues READ (0x03) + 24-bit address and
// returns one 16-bit word per request, first received byte in data[15:8].
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLKDIV = 2,
  parameter int CSHIGH = 4
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 req,
  input  logic [23:0]          addr,
  output logic                 busy,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 spi_sck,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int               GAP_W    = $clog2(CSHIGH + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSHIGH - 1);

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_q, rx_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [DATA_BITS-1:0]   data_q, data_d;

  logic sck_en, sck_rise, sck_fall;

  // The first SHIFT cycle (cs_n still high) only asserts chip select; the divider starts after it.
  assign sck_en = (state_q == SHIFT) && !cs_n_q;

  spi_sck_gen #(
    .CLKDIV(CLKDIV)
  ) u_sck_gen (
    .clk    (clk),
    .reset_b(reset_b),
    .en     (sck_en),
    .sck    (spi_sck),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          shift_d = {CMD_READ, addr, {DATA_BITS{1'b0}}};
          rx_d    = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          mosi_d = shift_q[FRAME_BITS-1];
        end else begin
          // Only the last 16 captured bits survive; command/address-phase MISO falls off the top.
          if (sck_rise) begin
            rx_d = {rx_q[DATA_BITS-2:0], spi_miso};
          end
          if (sck_fall) begin
            if (bit_q == LAST_BIT) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              valid_d = 1'b1;
              data_d  = rx_q;
              gap_d   = GAP_W'(1);
              state_d = GAP;
            end else begin
              shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
              mosi_d  = shift_q[FRAME_BITS-2];
              bit_d   = bit_q + BIT_CNT_W'(1);
            end
          end
        end
      end

      GAP: begin
        // The valid cycle is gap cycle 1; the IDLE cycle that follows is the last
        // cs_n-high cycle, so the next request is accepted CSHIGH cycles after valid.
        if (gap_q >= GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      shift_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data     = data_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Read-only SPI flash controller for the OPC5 system on the Avnet Microboard. It sequences the board's SPI flash through a standard READ (0x03) command with a 24-bit address and returns one 16-bit word per request. It sits between the opc5system memory/IO decode and the SPI_SCK / SPI_CS_n / SPI_IO pins, replacing their static tie-offs. Transfers are single-word and non-pipelined; one request is outstanding at a time.

## Interface
- CLKDIV, 2: clk cycles per SCK half-period; legal range ≥1.
- CSHIGH, 4: minimum clk cycles cs_n stays high between transfers; legal range ≥1.
- clk  in  1  system clock (USER_CLOCK domain).
- reset_b  in  1  reset; one clock, reset is synchronous and active-low.
- req  in  1  start a read; sampled only when busy=0.
- addr  in  24  flash byte address; captured on the accepting cycle.
- busy  out  1  high from the cycle after acceptance until CSHIGH expires.
- valid  out  1  one-cycle pulse; data is valid in this cycle.
- data  out  16  read word; first received byte is data[15:8]; held until next valid.
- spi_sck  out  1  SPI clock, mode 0 (idle low).
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial command/address out (SPI_IO1).
- spi_miso  in  1  serial data in (SPI_IO2).

## Operation
- Reset values: busy=0, valid=0, data=16'h0000, spi_sck=0, spi_cs_n=1, spi_mosi=0.
- States: IDLE, SHIFT, GAP.
- IDLE: if req=1, load 48-bit shift register {8'h03, addr, 16'h0000}, clear bit counter and divider, move to SHIFT. If req=0, stay in IDLE.
- SHIFT, entry cycle: cs_n=0, busy=1, mosi=shift[47], sck=0.
- SHIFT, bit cycle: low phase of CLKDIV clk cycles, then high phase of CLKDIV cycles.
- On the low→high edge: capture spi_miso into the receive shift register LSB.
- At the end of the high phase: sck=0, shift the transmit register left by one, present the new MSB on mosi, increment the bit counter.
- After 48 bit periods: cs_n=1, sck=0, mosi=0, valid=1 for one cycle, data = the last 16 bits captured. Move to GAP.
- MISO content during the 32 command/address bits is discarded.
- GAP: count CSHIGH cycles with cs_n=1 and busy=1, then return to IDLE with busy=0. The first valid cycle counts as GAP cycle 1.
- req while busy=1 is ignored. It is not queued and does not alter the transfer in progress.
- Address wrap at 24'hFFFFFF is the flash device's concern; this block does not check or wrap it.
- reset_b=0 mid-transfer: on the next edge all outputs return to their reset values and the state is IDLE. No valid is emitted for the aborted read.
- Divider width is $clog2(CLKDIV+1). Bit counter is 6 bits, terminal value 47.

## Timing
- Acceptance: req=1 at edge N (busy=0) → busy=1, cs_n=0 after edge N+1.
- First SCK rise: CLKDIV cycles after cs_n falls.
- Latency from accepting edge to valid: 1 + 96·CLKDIV cycles. CLKDIV=2 gives 193 cycles.
- SCK frequency is f_clk/(2·CLKDIV). At 40 MHz with CLKDIV=2, SCK is 10 MHz.
- mosi changes only on SCK-falling cycles, or at CS assertion for bit 47. It is stable for ≥CLKDIV cycles before each rise.
- Back-to-back: earliest next acceptance is CSHIGH cycles after valid. Request period = 1 + 96·CLKDIV + CSHIGH cycles.
- valid and the cs_n rise occur in the same cycle.

## Structure
- Package spi_flash_pkg holds:
  - CMD_READ = 8'h03
  - state typedef {IDLE, SHIFT, GAP}
  - FRAME_BITS = 48
  - DATA_BITS = 16
- Sub-module spi_sck_gen (divider + phase toggle, emits rise/fall strobes) is natural and reusable for a later write/erase controller. Everything else is a single FSM.

## Test plan
- Reset then CLKDIV=2, req with addr=24'h012345:
  - MOSI frame 0x03,0x01,0x23,0x45 MSB-first.
  - Model returns 0xBE,0xEF → valid at +193 cycles, data=16'hBEEF.
  - cs_n low for exactly 192 cycles.
- req held high continuously, CSHIGH=4: consecutive valids exactly 197 cycles apart; cs_n high ≥4 cycles between frames.
- req pulsed again at cycles 10 and 100 of an active transfer: no effect; exactly one valid; frame bits unchanged.
- reset_b low at cycle 60 of a transfer:
  - next edge cs_n=1, sck=0, busy=0, data=0.
  - no valid.
  - a new req=24'h000000 then completes normally.
- CLKDIV=1, addr=24'hFFFFFE, model returns 0x00,0xFF:
  - sck period 2 cycles; valid at +97 cycles, data=16'h00FF.
  - mosi never changes in a rising-edge cycle.
